idex_skid_stage: RTL
====================

Name: idex_skid_stage

Overview:
- Parametrised decode-to-execute pipeline stage register for the 24-bit SISP core.
- Replaces the free-running stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and bubble gating of control signals.
- A saturating stall counter is added for performance debug.
- Sits between the decode/register-file stage (upstream) and the ALU/execute stage (downstream).

Parameters:
- DATA_W, 24, width of rd1/rd2/extend payloads.
- RA_W, 4, width of destination register address.
- OPC_W, 4, width of opcode.
- ALUC_W, 2, width of ALU control field.
- STALL_CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries (branch taken).
- id_valid  in  1  upstream payload valid.
- id_ready  out  1  stage can accept; registered.
- rd1, rd2  in  DATA_W  register-file read data.
- extend  in  DATA_W  extended immediate.
- ra3  in  RA_W  destination register.
- opcode  in  OPC_W  instruction opcode.
- ctrl_in  in  6+ALUC_W-1 (ctrl_t)  {regWrite, aluSrc, pcSrc, memToReg, memWrite, aluControl}.
- ex_valid  out  1  downstream payload valid.
- ex_ready  in  1  execute stage consumes this cycle.
- src_a, src_b, ext_imm  out  DATA_W  held payload.
- wa3_e  out  RA_W; opcode_e  out  OPC_W; ctrl_e  out  ctrl_t.
- stall_cnt  out  STALL_CNT_W  cycles with ex_valid && !ex_ready, saturating.

Behaviour:
- Reset (async): ex_valid=0, id_ready=1, stall_cnt=0, skid empty, ctrl_e=0, all data outputs=0, state EMPTY.
- Transfers:
  - Upstream transfer = id_valid && id_ready.
  - Downstream transfer = ex_valid && ex_ready.
  - Latency: one cycle from upstream transfer to ex_valid when the main register is empty.
- States (2-bit enum), transitions on posedge clk:
  - EMPTY (main and skid empty):
    - Upstream transfer loads main -> BUSY.
  - BUSY (main full, skid empty):
    - Accept and consume together: main reloads, stay BUSY.
    - Consume only -> EMPTY.
    - Accept without consume: payload goes to skid -> FULL; id_ready drops next cycle.
  - FULL (main and skid full, id_ready=0):
    - Consume: skid moves to main, skid clears -> BUSY; id_ready=1 next cycle.
- id_ready is driven from a flop: 1 in EMPTY/BUSY, 0 in FULL. There is no combinational path from ex_ready to id_ready.
- Payload ordering is strictly FIFO; the skid entry never overtakes main.
- Bubble gating: ctrl_e is forced to all-zero whenever ex_valid=0, so a bubble can never write the register file or memory. Data outputs may hold stale values when invalid.
- Flush:
  - Next state is EMPTY, ex_valid=0, ctrl_e=0, id_ready=1.
  - Any same-cycle upstream transfer is discarded; flush has priority over accept and consume.
  - stall_cnt is unaffected.
- stall_cnt increments by 1 each cycle with ex_valid && !ex_ready. It holds at all-ones and never wraps. It clears only on rst.
- Reset mid-operation: any held entries are lost, outputs return to reset values immediately (asynchronous), and no partial transfer completes.
- id_valid with id_ready=0: the payload is ignored; upstream must hold it.

Decomposition:
- Package sisp_pipe_pkg holds:
  - ctrl_t packed struct {regWrite, aluSrc, pcSrc, memToReg, memWrite, aluControl[ALUC_W-1:0]}.
  - CTRL_NOP constant (all zero).
  - stage_state_t enum {EMPTY, BUSY, FULL}.
- One natural sub-module: pipe_skid_buf. It is a generic payload-width skid buffer with valid/ready, flush and state FSM.
- idex_skid_stage packs {rd1, rd2, extend, ra3, opcode, ctrl_in} into the sub-module, unpacks the result, and adds control gating and stall_cnt.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-traffic.
  - Response: same cycle ex_valid=0, ctrl_e=0, stall_cnt=0, id_ready=1; after release, first accepted rd1=24'h00ABCD appears on src_a one cycle later.
- Streaming:
  - Stimulus: ex_ready=1, id_valid=1 for 8 cycles, rd1=i.
  - Response: src_a sequence 0..7 with one-cycle latency, id_ready stays 1, stall_cnt stays 0.
- Backpressure and skid:
  - Stimulus: hold ex_ready=0 while sending A, B, C.
  - Response: A in main, B in skid, id_ready=0, C held upstream; release ex_ready: outputs A, B, C in order, none lost or duplicated, stall_cnt equals the stall cycles.
- Flush:
  - Stimulus: FULL with regWrite=1 entries, pulse flush together with id_valid=1.
  - Response: next cycle ex_valid=0, ctrl_e=0, id_ready=1, and the same-cycle payload is not delivered.
- Bubble gating:
  - Stimulus: id_valid=0 with ctrl_in memWrite=1.
  - Response: ctrl_e.memWrite=0 and ex_valid=0 every cycle.
- Counter saturation:
  - Stimulus: STALL_CNT_W=4, hold stall for 20 cycles.
  - Response: stall_cnt reaches 4'hF and holds.

Source files
------------

// File: rtl/sisp_pipe_pkg.sv
// ---------------------------------------------------------------------------
// sisp_pipe_pkg
// Shared types for the SISP core pipeline stage registers.
//   ctrl_t         : packed control bundle carried from decode to execute
//   CTRL_NOP       : all-zero control word (a bubble that writes nothing)
//   stage_state_t  : occupancy state of a skid-buffered stage register
// ---------------------------------------------------------------------------
package sisp_pipe_pkg;

  localparam int PKG_ALUC_W = 2;

  typedef struct packed {
    logic                  regWrite;
    logic                  aluSrc;
    logic                  pcSrc;
    logic                  memToReg;
    logic                  memWrite;
    logic [PKG_ALUC_W-1:0] aluControl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // EMPTY: nothing held; BUSY: main entry only; FULL: main plus skid entry
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Generic one-entry skid buffer with valid/ready handshake on both sides.
// The "main" register feeds the output; the "skid" register catches the one
// payload that arrives while the output is stalled, so in_ready can be a
// flop instead of a combinational function of out_ready.
// Ports:
//   clk, rst        : clock (rising edge), async active-high reset
//   flush           : synchronous discard of all held entries
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
// ---------------------------------------------------------------------------
import sisp_pipe_pkg::*;

module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  stage_state_t state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         up_xfer;
  logic         dn_xfer;

  // Both handshakes use only registered signals on this side, so neither
  // in_ready nor out_valid has a combinational path through the stage.
  assign up_xfer  = in_valid && in_ready;
  assign dn_xfer  = out_valid && out_ready;
  assign out_data = main_q;

  // Occupancy FSM. out_valid and in_ready are registered alongside the
  // state so they always agree with it: out_valid is "state != EMPTY" and
  // in_ready is "state != FULL". Flush wins over any transfer that cycle.
  // The skid entry only ever moves into main, never past it, which keeps
  // the stage strictly first-in first-out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (up_xfer) begin
            main_q    <= in_data;
            out_valid <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (up_xfer && dn_xfer) begin
            main_q <= in_data;
          end else if (dn_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (up_xfer) begin
            skid_q   <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end
        end
        FULL: begin
          if (dn_xfer) begin
            main_q   <= skid_q;
            skid_q   <= '0;
            in_ready <= 1'b1;
            state    <= BUSY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/idex_skid_stage.sv
// ---------------------------------------------------------------------------
// idex_skid_stage
// Decode-to-execute stage register for the 24-bit SISP core. Wraps a
// pipe_skid_buf around the packed decode payload, forces the control word
// to NOP whenever the stage holds no valid instruction, and keeps a
// saturating count of cycles the execute stage spent stalling us.
// Ports:
//   clk, rst                 : clock (rising edge), async active-high reset
//   flush                    : synchronous kill of held entries (branch taken)
//   id_valid / id_ready      : decode-side handshake (id_ready registered)
//   rd1, rd2, extend, ra3, opcode, ctrl_in : decode payload
//   ex_valid / ex_ready      : execute-side handshake
//   src_a, src_b, ext_imm, wa3_e, opcode_e, ctrl_e : execute payload
//   stall_cnt                : cycles with ex_valid && !ex_ready, saturating
// ---------------------------------------------------------------------------
import sisp_pipe_pkg::*;

module idex_skid_stage #(
  parameter int DATA_W      = 24,
  parameter int RA_W        = 4,
  parameter int OPC_W       = 4,
  parameter int ALUC_W      = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [DATA_W-1:0]      rd1,
  input  logic [DATA_W-1:0]      rd2,
  input  logic [DATA_W-1:0]      extend,
  input  logic [RA_W-1:0]        ra3,
  input  logic [OPC_W-1:0]       opcode,
  input  ctrl_t                  ctrl_in,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [DATA_W-1:0]      src_a,
  output logic [DATA_W-1:0]      src_b,
  output logic [DATA_W-1:0]      ext_imm,
  output logic [RA_W-1:0]        wa3_e,
  output logic [OPC_W-1:0]       opcode_e,
  output ctrl_t                  ctrl_e,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Five single-bit control flags plus the ALU control field.
  localparam int CTRL_W = 5 + ALUC_W;
  localparam int PAY_W  = 3 * DATA_W + RA_W + OPC_W + CTRL_W;

  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;
  logic [CTRL_W-1:0] ctrl_raw;
  logic [CTRL_W-1:0] ctrl_pack;

  assign ctrl_pack = ctrl_in;
  assign pay_in    = {rd1, rd2, extend, ra3, opcode, ctrl_pack};

  pipe_skid_buf #(
    .W(PAY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (id_valid),
    .in_ready  (id_ready),
    .in_data   (pay_in),
    .out_valid (ex_valid),
    .out_ready (ex_ready),
    .out_data  (pay_out)
  );

  assign {src_a, src_b, ext_imm, wa3_e, opcode_e, ctrl_raw} = pay_out;

  // Bubble gating: the data fields may hold stale values after a consume or
  // flush, but the control word must never let a bubble write the register
  // file or memory, so it is zeroed whenever the stage is not valid.
  always_comb begin
    ctrl_e = CTRL_NOP;
    if (ex_valid) begin
      ctrl_e = ctrl_t'(ctrl_raw);
    end
  end

  // Stall counter for performance debug. It counts every cycle the execute
  // stage refuses a valid entry, sticks at all-ones rather than wrapping so
  // a long stall is never misread as a short one, and is deliberately left
  // alone by flush so it accumulates across branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (ex_valid && !ex_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
